// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC/fetch stage and the control unit that drives PS/PCsel/K.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // PS(2) + PCsel(1) + K(64) slice of the control word
  localparam int CW_BITS = 67;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Next-PC arithmetic for the fetch stage; purely combinational, all math modulo 2^64.
module pc_next_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [1:0]  ps,
  input  logic [63:0] sel_in,
  output logic [63:0] next_pc,
  output logic        misaligned
);

  logic [63:0] pc_inc;

  always_comb begin
    pc_inc = pc + 64'd4;
    case (ps)
      PS_HOLD: next_pc = pc;
      PS_INC:  next_pc = pc_inc;
      PS_LOAD: next_pc = sel_in;
      default: next_pc = pc_inc + {sel_in[61:0], 2'b00};
    endcase
    misaligned = (ps != PS_HOLD) && (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch over a req/ack handshake, feeding one instruction at a time to the control unit.
//
// state    | meaning
// ST_FETCH | request imem at pc, wait for ack, latch instruction
// ST_EXEC  | instruction valid; PS selects next pc, PS=00 holds
// ST_FAULT | misaligned target seen; frozen until reset
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  PS,
  input  logic        PCsel,
  input  logic [63:0] K,
  input  logic [63:0] reg_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fault,
  output logic [31:0] instr_count
);

  fetch_state_t state, state_next;
  logic [63:0]  sel_in;
  logic [63:0]  next_pc;
  logic         misaligned;

  assign sel_in = PCsel ? K : reg_in;

  pc_next_calc u_pc_next_calc (
    .pc         (pc),
    .ps         (PS),
    .sel_in     (sel_in),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: if (imem_ack) state_next = ST_EXEC;
      ST_EXEC: begin
        if (PS != PS_HOLD) state_next = misaligned ? ST_FAULT : ST_FETCH;
      end
      default: state_next = ST_FAULT;
    endcase
  end

  // Gated by reset so the handshake stays quiet while reset is held.
  always_comb begin
    imem_req    = (state == ST_FETCH) && !reset;
    instr_valid = (state == ST_EXEC) && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      instruction <= 32'd0;
      fault       <= 1'b0;
      instr_count <= 32'd0;
    end else begin
      if (state == ST_FETCH && imem_ack) instruction <= imem_rdata;
      if (state == ST_EXEC && PS != PS_HOLD) begin
        if (misaligned) begin
          fault <= 1'b1;
        end else begin
          pc          <= next_pc;
          instr_count <= instr_count + 32'd1;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 64'd4;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage directly upstream of the control unit. Holds the 64-bit PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents one instruction at a time to the control unit. Consumes the control unit's PS/PCsel/K fields to compute the next PC, so multi-cycle instructions (PS = 00) stall fetch.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; must be word-aligned.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PS  in  2  PC select from control word: 00 hold, 01 PC+4, 10 PC<-in, 11 PC<-PC+4+in*4
- PCsel  in  1  source of `in`: 1 = K, 0 = reg_in
- K  in  64  literal from control unit
- reg_in  in  64  register-file bus A (BR target)
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  64  fetch address, equals pc while imem_req=1
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instruction  out  32  instruction register to control unit
- instr_valid  out  1  instruction is valid; PS/PCsel/K/reg_in are sampled only when high
- pc  out  64  current PC
- pc_plus4  out  64  pc+4, link value for BL
- fault  out  1  sticky misaligned-target flag
- instr_count  out  32  instructions retired

## Operation
- States: FETCH, EXEC, FAULT. Reset enters FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instruction<=imem_rdata, go EXEC. No ack: stay, address stable.
- EXEC: instr_valid=1. in = PCsel ? K : reg_in.
  - PS=00: PC unchanged, stay EXEC (multi-cycle instruction).
  - PS=01: pc<=pc+4.
  - PS=10: pc<=in.
  - PS=11: pc<=pc+4+(in<<2).
  - For PS≠00: instr_count<=instr_count+1; target[1:0]≠0 -> fault<=1, pc unchanged, go FAULT, count not incremented; otherwise go FETCH.
- FAULT: imem_req=0, instr_valid=0, all state held until reset.
- Arithmetic modulo 2^64; (in<<2) discards in[63:62]; wrap silently. instr_count wraps 2^32-1 -> 0.
- imem_ack outside FETCH is ignored. instruction holds last fetched value outside FETCH->EXEC load.

## Timing
- Reset values (cycle after reset sampled high): pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, fault=0, instr_count=0, state=FETCH. imem_req/instr_valid are state decodes, so imem_req=1 in the first cycle after reset deasserts.
- Zero-wait memory (ack in the first FETCH cycle): FETCH 1 cycle, EXEC from next cycle; single-cycle instruction = 2 cycles/instr.
- Each wait cycle adds 1 cycle in FETCH.
- PC update and state transition on the same edge; new pc visible on imem_addr the following cycle.
- Reset mid-FETCH or mid-EXEC: abort; any ack on the reset cycle discarded.
- pc_plus4 is combinational from pc.

## Structure
- Shared defines file: PS encodings (PS_HOLD, PS_INC, PS_LOAD, PS_REL), state encodings, CW_BITS shared with the control unit.
- One sub-module: pc_next_calc (combinational: pc, PS, in -> next_pc, misaligned), separately testable.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory -> imem_addr=0x100 cycle 1; instr_valid cycle 2; PS=01 -> imem_addr=0x104 cycle 3, instr_count=1.
- 3-cycle ack delay -> imem_req and imem_addr=0x104 stable 3 cycles; instruction latched on ack; instr_valid next cycle.
- EXEC with PS=00 for 2 cycles then 01 -> pc unchanged for 2 cycles, instr_count +1 only once.
- pc=0x200, PS=11, PCsel=1, K=-2 (all ones <<1) -> next pc=0x1FC; K=0x3FFFFFFFFFFFFFFF at pc=0 -> wraps to 0x0.
- PS=10, PCsel=0, reg_in=0x302 -> fault=1, imem_req=0 forever, pc unchanged; reset clears to RESET_PC.
- Reset asserted during FETCH with imem_ack=1 same cycle -> instruction=0, pc=RESET_PC, instr_count=0.
